// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

    localparam int unsigned MEM_BYTES_DEF = 1024;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    typedef enum logic {
        SEL_FETCH = 1'b0,
        SEL_LOAD  = 1'b1
    } sel_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Misaligned or past the last full word of memory.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > ADDR_W'(mem_bytes - 32'd4));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = fetch, bit 1 = loader.
module rr_arb2
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    sel_e last_q;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        gnt_c = req;
        if (req == 2'b11) begin
            gnt_c = (last_q == SEL_LOAD) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SEL_LOAD;
        end else if (gnt_c[0]) begin
            last_q <= SEL_FETCH;
        end else if (gnt_c[1]) begin
            last_q <= SEL_LOAD;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one instruction memory between a fetch port and a loader port,
// with a loader lock mode and single-cycle registered responses.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic              l_err,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [CNT_W-1:0]  err_cnt
);

    state_e   state_q;
    state_e   state_d;
    logic     f_allow_c;
    logic     l_allow_c;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic     acc_err_c;
    mem_req_t mreq_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A fetch granted in the locking cycle still owes a response, so drain first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (l_lock) state_d = arb_gnt[0] ? ST_DRAIN : ST_LOCKED;
            ST_DRAIN:  state_d = ST_LOCKED;
            ST_LOCKED: if (!l_lock) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        f_allow_c = 1'b0;
        l_allow_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                f_allow_c = 1'b1;
                l_allow_c = 1'b1;
            end
            ST_LOCKED: l_allow_c = 1'b1;
            default: ;
        endcase
    end

    assign arb_req = {l_req & l_allow_c, f_req & f_allow_c} & {2{rst_n}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .gnt_c (arb_gnt)
    );

    assign f_gnt = arb_gnt[0];
    assign l_gnt = arb_gnt[1];

    // Memory port follows whichever port won this cycle; errors never write.
    always_comb begin
        mreq_c    = '0;
        acc_err_c = 1'b0;
        if (arb_gnt[0]) begin
            acc_err_c   = addr_bad(f_addr, MEM_BYTES);
            mreq_c.addr = f_addr;
        end else if (arb_gnt[1]) begin
            acc_err_c    = addr_bad(l_addr, MEM_BYTES);
            mreq_c.addr  = l_addr;
            mreq_c.we    = l_we & ~acc_err_c;
            mreq_c.wdata = mreq_c.we ? l_wdata : '0;
        end
    end

    assign m_addr  = mreq_c.addr;
    assign m_we    = mreq_c.we;
    assign m_wdata = mreq_c.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            f_err    <= 1'b0;
            f_rdata  <= '0;
            l_rvalid <= 1'b0;
            l_err    <= 1'b0;
            l_rdata  <= '0;
            err_cnt  <= '0;
        end else begin
            f_rvalid <= arb_gnt[0];
            f_err    <= arb_gnt[0] & acc_err_c;
            f_rdata  <= (arb_gnt[0] && !acc_err_c) ? m_rdata : '0;
            l_rvalid <= arb_gnt[1];
            l_err    <= arb_gnt[1] & acc_err_c;
            l_rdata  <= (arb_gnt[1] && !acc_err_c && !l_we) ? m_rdata : '0;
            if ((|arb_gnt) && acc_err_c && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a response scoreboard and a byte memory model.
module tb_imem_arbiter;

    localparam int unsigned MB = 1024;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid, f_err;
    logic [31:0] f_rdata;
    logic        l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic        l_gnt, l_rvalid, l_err;
    logic [31:0] l_rdata;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_we;
    logic [15:0] err_cnt;

    rsp_t        fq[$];
    rsp_t        lq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = '0;
    logic [7:0]  mem [0:MB-1];
    logic [31:0] ref_mem [int];

    imem_arbiter #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_err(l_err), .l_rdata(l_rdata),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: combinational little-endian read, 4-byte write on the clock.
    always_comb begin
        int a;
        a = int'(m_addr[9:0]);
        m_rdata = '0;
        if (m_addr <= 32'd1020) m_rdata = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    end

    always @(posedge clk) begin
        int a;
        a = int'(m_addr[9:0]);
        if (m_we && m_addr <= 32'd1020) begin
            mem[a]   <= m_wdata[7:0];
            mem[a+1] <= m_wdata[15:8];
            mem[a+2] <= m_wdata[23:16];
            mem[a+3] <= m_wdata[31:24];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > 32'd1020);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] d);
        int i;
        i = int'(a);
        ref_mem[i] = d;
        mem[i] = d[7:0]; mem[i+1] = d[15:8]; mem[i+2] = d[23:16]; mem[i+3] = d[31:24];
    endtask

    // Response checker: exactly one response per grant, one cycle later.
    always @(negedge clk) begin
        if (rst_n) begin
            rsp_t e;
            chk("f_rvalid", 32'(f_rvalid), 32'(fq.size() != 0));
            if (fq.size() != 0) begin
                e = fq.pop_front();
                chk("f_rdata", f_rdata, e.data);
                chk("f_err", 32'(f_err), 32'(e.err));
            end
            chk("l_rvalid", 32'(l_rvalid), 32'(lq.size() != 0));
            if (lq.size() != 0) begin
                e = lq.pop_front();
                chk("l_rdata", l_rdata, e.data);
                chk("l_err", 32'(l_err), 32'(e.err));
            end
            chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        end
    end

    task automatic check_reset_outs();
        chk("rst_f_gnt", 32'(f_gnt), 0);
        chk("rst_l_gnt", 32'(l_gnt), 0);
        chk("rst_f_rvalid", 32'(f_rvalid), 0);
        chk("rst_l_rvalid", 32'(l_rvalid), 0);
        chk("rst_f_err", 32'(f_err), 0);
        chk("rst_l_err", 32'(l_err), 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_l_rdata", l_rdata, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_we", 32'(m_we), 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f_req = 0; l_req = 0; l_we = 0; l_lock = 0;
        fq.delete(); lq.delete();
        exp_cnt = '0;
        @(negedge clk);
        #1 check_reset_outs();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One cycle: drive at the falling edge, check grant/memory port, queue the expected response.
    task automatic cyc(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] lwd, input logic lk,
                       input logic eg_f, input logic eg_l);
        rsp_t e;
        logic er;
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd; l_lock = lk;
        #1;
        chk("f_gnt", 32'(f_gnt), 32'(eg_f));
        chk("l_gnt", 32'(l_gnt), 32'(eg_l));
        er = 1'b0;
        if (eg_f) begin
            er = bad(fa);
            chk("m_addr_f", m_addr, fa);
            chk("m_we_f", 32'(m_we), 0);
            e.err = er; e.data = er ? 32'h0 : ref_rd(fa);
            fq.push_back(e);
        end else if (eg_l) begin
            er = bad(la);
            chk("m_addr_l", m_addr, la);
            chk("m_we_l", 32'(m_we), 32'(lw && !er));
            if (lw && !er) begin
                chk("m_wdata", m_wdata, lwd);
                ref_mem[int'(la)] = lwd;
            end
            e.err = er; e.data = (er || lw) ? 32'h0 : ref_rd(la);
            lq.push_back(e);
        end else begin
            chk("m_we_idle", 32'(m_we), 0);
        end
        if (er && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < int'(MB); i++) mem[i] = 8'h00;
        put_word(32'h10, 32'hDEADBEEF);
        put_word(32'h20, 32'h11223344);
        put_word(32'h40, 32'hCAFEF00D);
        do_reset();

        // Lone fetch read.
        cyc(1, 32'h10, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Tie sequence from reset: fetch wins first, then alternation.
        do_reset();
        repeat (2) begin
            cyc(1, 32'h20, 1, 0, 32'h40, 0, 0, 1, 0);
            cyc(1, 32'h20, 1, 0, 32'h40, 0, 0, 0, 1);
        end
        idle(1);

        // Loader write at the last word, read back, then a misaligned write.
        cyc(0, 0, 1, 1, 32'h3FC, 32'h12345678, 0, 0, 1);
        cyc(0, 0, 1, 0, 32'h3FC, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 32'h3FE, 32'hA5A5A5A5, 0, 0, 1);
        idle(1);

        // Lock while a fetch is granted: drain, lock, release.
        cyc(1, 32'h10, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 32'h10, 1, 0, 32'h40, 0, 1, 0, 0);
        cyc(1, 32'h10, 1, 0, 32'h40, 0, 1, 0, 1);
        cyc(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h10, 0, 0, 0, 0, 0, 1, 0);
        // Lock with no fetch outstanding goes straight to locked.
        cyc(0, 0, 1, 0, 32'h40, 0, 1, 0, 1);
        cyc(1, 32'h20, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h20, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Fetch errors: out of range, misaligned, then saturate the counter.
        cyc(1, 32'h400, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 32'h11, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 65540; i++) cyc(1, 32'h400, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        chk("err_cnt_sat", 32'(err_cnt), 32'h0000FFFF);

        // Reset in the cycle after a grant discards the response.
        f_req = 1; f_addr = 32'h10;
        #1 chk("pre_rst_f_gnt", 32'(f_gnt), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        fq.delete(); lq.delete();
        exp_cnt = '0;
        #1 check_reset_outs();
        f_req = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        idle(3);

        chk("fq_drained", 32'(fq.size()), 0);
        chk("lq_drained", 32'(lq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 1024, meaning byte size of the shared instruction memory (power of two, 16..65536).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 f_req  input  1  fetch port read request.
REQ-005 f_addr  input  32  fetch byte address.
REQ-006 f_gnt  output  1  fetch request accepted this cycle.
REQ-007 f_rvalid  output  1  fetch response valid.
REQ-008 f_rdata  output  32  fetch response word, little-endian.
REQ-009 f_err  output  1  fetch response is an error; qualified by f_rvalid.
REQ-010 l_req  input  1  loader port request.
REQ-011 l_we  input  1  loader write (1) / read (0).
REQ-012 l_addr  input  32  loader byte address.
REQ-013 l_wdata  input  32  loader write word, little-endian.
REQ-014 l_lock  input  1  loader requests exclusive ownership of the memory.
REQ-015 l_gnt, l_rvalid, l_err  output  1 each  loader grant, response valid, response error.
REQ-016 l_rdata  output  32  loader response word.
REQ-017 m_addr  output  32  memory byte address.
REQ-018 m_we  output  1  memory write strobe, 4 bytes at m_addr..m_addr+3.
REQ-019 m_wdata  output  32  memory write word.
REQ-020 m_rdata  input  32  memory read word, combinational from m_addr, {byte3,byte2,byte1,byte0}.
REQ-021 err_cnt  output  16  saturating count of error responses.

Function
REQ-022 FSM states RUN, LOCKED, DRAIN; at most one memory access per cycle.
REQ-023 RUN: both requesting -> round-robin (grant the port not granted last); single requester granted immediately.
REQ-024 RUN -> DRAIN when l_lock=1 and a fetch response is due next cycle; RUN -> LOCKED when l_lock=1 and none is due.
REQ-025 DRAIN -> LOCKED after one cycle; DRAIN grants no request.
REQ-026 LOCKED: only loader granted, f_gnt=0; LOCKED -> RUN the cycle after l_lock=0.
REQ-027 Grant is combinational in the request cycle; m_addr/m_we/m_wdata driven from the granted port in that cycle, m_we=0 when no write granted.
REQ-028 Response latency exactly 1 cycle: rvalid on the granted port in cycle N+1, rdata registered from m_rdata in cycle N.
REQ-029 Writes get one rvalid ack cycle with rdata=0.
REQ-030 Error when addr[1:0]!=0 or addr>MEM_BYTES-4: grant still given, memory not accessed (m_we=0), rvalid with err=1 and rdata=0 next cycle.
REQ-031 err_cnt increments by 1 per error response, saturates at 0xFFFF.
REQ-032 Requests not granted hold; no request is dropped or reordered per port.
REQ-033 Last-grant pointer updates only on a granted access; error grants count as granted.

Reset
REQ-034 rst_n low: state=RUN, last-grant pointer=loader (fetch wins first tie), all gnt/rvalid/err=0, rdata=0, m_we=0, m_addr=0, m_wdata=0, err_cnt=0.
REQ-035 Reset mid-operation discards any pending response; no rvalid after deassertion without a new grant.

Structure
REQ-036 Shared package imem_pkg holds the state enum, port-select encoding (SEL_FETCH=0, SEL_LOAD=1) and default MEM_BYTES.
REQ-037 One sub-module rr_arb2: 2-input round-robin arbiter with pointer register.

Verification
REQ-038 f_req only, f_addr=0x10, m_rdata=0xDEADBEEF -> f_gnt same cycle, f_rvalid next cycle, f_rdata=0xDEADBEEF, f_err=0.
REQ-039 f_req and l_req held 4 cycles after reset -> grants F,L,F,L.
REQ-040 l_lock=1 while a fetch is granted -> DRAIN one cycle, then LOCKED, f_gnt=0 until one cycle after l_lock=0.
REQ-041 l_we=1, l_addr=0x3FC, l_wdata=0x12345678 -> m_we=1, m_addr=0x3FC, l_rvalid next cycle, l_rdata=0; l_addr=0x3FE -> l_err=1, m_we=0, err_cnt+1.
REQ-042 f_addr=0x400 with MEM_BYTES=1024 -> f_err=1; err_cnt preloaded to 0xFFFF by repeated errors stays 0xFFFF.
REQ-043 rst_n pulsed low in the cycle after a grant -> no rvalid, all outputs at reset values.
